// File: rtl/dcache_write_buffer.sv
// D-cache write buffer: posts writes into a circular FIFO drained over AXI4-Lite,
// and services reads only once every buffered write has been acknowledged.
module dcache_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] up_addr,
   input  logic        up_rd,
   input  logic        up_wr,
   input  logic [31:0] up_wdata,
   input  logic [3:0]  up_wstrb,
   output logic [31:0] up_rdata,
   output logic        up_valid,
   output logic        wb_empty,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {D_IDLE, D_SEND, D_RESP} drain_state_t;
   typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ADDR, R_DATA} read_state_t;

   logic [31:0]      r_addr_q [DEPTH];
   logic [31:0]      r_data_q [DEPTH];
   logic [3:0]       r_strb_q [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   drain_state_t     r_d_state;
   drain_state_t     w_d_next;
   read_state_t      r_r_state;
   read_state_t      w_r_next;

   logic             r_aw_done;
   logic             r_w_done;
   logic             r_up_valid;
   logic [31:0]      r_up_rdata;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_rd_start;
   logic             w_rd_done;
   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_send_done;

   // A full buffer may still accept in the cycle that frees its head entry.
   assign w_full      = (r_count == DEPTH_C);
   assign w_pop       = (r_d_state == D_RESP) && bvalid;
   assign w_push      = up_wr && !r_up_valid && (r_r_state == R_IDLE) && (!w_full || w_pop);
   assign w_rd_start  = up_rd && !up_wr && !r_up_valid && (r_r_state == R_IDLE);
   assign w_rd_done   = (r_r_state == R_DATA) && rvalid;

   assign w_aw_hs     = awvalid && awready;
   assign w_w_hs      = wvalid && wready;
   assign w_send_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

   assign wb_empty    = (r_count == '0) && (r_d_state == D_IDLE);
   assign up_valid    = r_up_valid;
   assign up_rdata    = r_up_rdata;

   // The head entry only moves on a pop in D_RESP, so the write channel stays stable.
   assign awaddr      = r_addr_q[r_head];
   assign wdata       = r_data_q[r_head];
   assign wstrb       = r_strb_q[r_head];
   assign araddr      = up_addr;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_q[r_tail] <= up_addr;
         r_data_q[r_tail] <= up_wdata;
         r_strb_q[r_tail] <= up_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_up_valid <= 1'b0;
         r_up_rdata <= '0;
      end else begin
         r_up_valid <= w_push || w_rd_done;
         if (w_rd_done) begin
            r_up_rdata <= rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d_state <= D_IDLE;
      end else begin
         r_d_state <= w_d_next;
      end
   end

   // AW and W complete independently; the flags remember which one already went.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if ((r_d_state == D_SEND) && !w_send_done) begin
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_w_done <= 1'b1;
         end
      end else begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end
   end

   always_comb begin
      w_d_next = r_d_state;
      case (r_d_state)
         D_IDLE:  if (r_count != '0) w_d_next = D_SEND;
         D_SEND:  if (w_send_done)   w_d_next = D_RESP;
         D_RESP:  if (bvalid)        w_d_next = D_IDLE;
         default:                    w_d_next = D_IDLE;
      endcase
   end

   always_comb begin
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      case (r_d_state)
         D_SEND: begin
            awvalid = !r_aw_done;
            wvalid  = !r_w_done;
         end
         D_RESP:  bready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_r_state <= R_IDLE;
      end else begin
         r_r_state <= w_r_next;
      end
   end

   // Reads wait for a fully drained buffer; there is no forwarding from the FIFO.
   always_comb begin
      w_r_next = r_r_state;
      case (r_r_state)
         R_IDLE:  if (w_rd_start) w_r_next = R_DRAIN;
         R_DRAIN: if (wb_empty)   w_r_next = R_ADDR;
         R_ADDR:  if (arready)    w_r_next = R_DATA;
         R_DATA:  if (rvalid)     w_r_next = R_IDLE;
         default:                 w_r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arvalid = 1'b0;
      rready  = 1'b0;
      case (r_r_state)
         R_ADDR:  arvalid = 1'b1;
         R_DATA:  rready  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a negedge-driven AXI4-Lite slave model.
module tb_dcache_write_buffer;

   localparam int DEPTH = 4;
   localparam int LIMIT = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] up_addr;
   logic        up_rd;
   logic        up_wr;
   logic [31:0] up_wdata;
   logic [3:0]  up_wstrb;
   logic [31:0] up_rdata;
   logic        up_valid;
   logic        wb_empty;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;

   logic        aw_en, w_en, b_en, ar_en;
   logic [31:0] rd_val;
   logic [31:0] aw_q [$];
   logic [35:0] w_q [$];
   logic [31:0] ar_q [$];
   int          aw_tot = 0;
   int          w_tot = 0;
   int          b_tot = 0;
   int          r_pend = 0;
   int          cyc = 0;
   int          first_b_edge = -1;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dcache_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .up_addr(up_addr), .up_rd(up_rd), .up_wr(up_wr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
      .up_rdata(up_rdata), .up_valid(up_valid), .wb_empty(wb_empty),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready)
   );

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Slave: drives at negedge; a handshake seen here completes at the next posedge.
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      forever begin
         @(negedge clk);
         awready = aw_en;
         wready  = w_en;
         arready = ar_en;
         bvalid  = b_en && (((aw_tot < w_tot) ? aw_tot : w_tot) > b_tot);
         if (bvalid && bready) begin
            if (b_tot == 0) first_b_edge = cyc + 1;
            b_tot++;
         end
         if (awvalid && awready) begin aw_q.push_back(awaddr); aw_tot++; end
         if (wvalid && wready) begin w_q.push_back({wdata, wstrb}); w_tot++; end
         rvalid = (r_pend != 0);
         rdata  = rvalid ? rd_val : 32'h0;
         if (rvalid && rready) r_pend = 0;
         if (arvalid && arready) begin ar_q.push_back(araddr); r_pend = 1; end
      end
   end

   function automatic logic [31:0] aw_at(input int i);
      return (i < aw_q.size()) ? aw_q[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [35:0] w_at(input int i);
      return (i < w_q.size()) ? w_q[i] : 36'hx_xxxx_xxxx;
   endfunction

   function automatic logic [31:0] ar_at(input int i);
      return (i < ar_q.size()) ? ar_q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_clear();
      aw_q.delete(); w_q.delete(); ar_q.delete();
      aw_tot = 0; w_tot = 0; b_tot = 0; r_pend = 0; first_b_edge = -1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin tick(); n++; end while (up_valid !== 1'b1 && n < LIMIT);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int n);
      up_addr = a; up_wdata = d; up_wstrb = s; up_wr = 1'b1;
      wait_valid(n);
      up_wr = 1'b0;
   endtask

   task automatic wait_empty(output bit ok);
      int n;
      n = 0;
      while (wb_empty !== 1'b1 && n < LIMIT) begin tick(); n++; end
      ok = (wb_empty === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; up_wr = 1'b0; up_rd = 1'b0;
      tick(); tick();
      n_cmp++; if (up_valid !== 1'b0) begin n_err++; $display("FAIL rst_up_valid: got %b want 0", up_valid); end
      n_cmp++; if (up_rdata !== 32'h0) begin n_err++; $display("FAIL rst_up_rdata: got %h want 0", up_rdata); end
      n_cmp++; if (awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid: got %b want 0", awvalid); end
      n_cmp++; if (wvalid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid: got %b want 0", wvalid); end
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
      n_cmp++; if (bready !== 1'b0) begin n_err++; $display("FAIL rst_bready: got %b want 0", bready); end
      n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", rready); end
      n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL rst_wb_empty: got %b want 1", wb_empty); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      int n;
      bit ok;
      slave_clear(); aw_en = 1'b1; w_en = 1'b1; b_en = 1'b1; ar_en = 1'b1;
      do_write(32'h100, 32'hDEADBEEF, 4'hF, n);
      n_cmp++; if (n != 1) begin n_err++; $display("FAIL wr_latency: got %0d cycles want 1", n); end
      tick();
      n_cmp++; if (up_valid !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: got %b want 0", up_valid); end
      wait_empty(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_drain: got wb_empty %b want 1", wb_empty); end
      n_cmp++; if (aw_q.size() != 1) begin n_err++; $display("FAIL wr_aw_beats: got %0d want 1", aw_q.size()); end
      n_cmp++; if (aw_at(0) !== 32'h100) begin n_err++; $display("FAIL wr_awaddr: got %h want 00000100", aw_at(0)); end
      n_cmp++; if (w_at(0) !== {32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL wr_wbeat: got %h want deadbeeff", w_at(0)); end
      n_cmp++; if (b_tot != 1) begin n_err++; $display("FAIL wr_b_count: got %0d want 1", b_tot); end
   endtask

   task automatic test_back_to_back();
      int n, pulses, held;
      bit ok;
      slave_clear(); aw_en = 1'b0; w_en = 1'b1; b_en = 1'b1;
      pulses = 0;
      for (int i = 0; i < DEPTH; i++) begin
         do_write(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, n);
         if (up_valid === 1'b1) pulses++;
      end
      n_cmp++; if (pulses != DEPTH) begin n_err++; $display("FAIL b2b_accepted: got %0d want %0d", pulses, DEPTH); end
      up_addr = 32'h1010; up_wdata = 32'hA4; up_wstrb = 4'hF; up_wr = 1'b1;
      held = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (up_valid === 1'b1) held++;
      end
      n_cmp++; if (held != 0) begin n_err++; $display("FAIL b2b_fifth_held: got %0d pulses want 0", held); end
      aw_en = 1'b1;
      wait_valid(n);
      up_wr = 1'b0;
      n_cmp++; if (up_valid !== 1'b1) begin n_err++; $display("FAIL b2b_fifth_accept: got %b want 1", up_valid); end
      n_cmp++; if (cyc != first_b_edge) begin n_err++; $display("FAIL b2b_push_in_pop_cycle: got edge %0d want %0d", cyc, first_b_edge); end
      wait_empty(ok);
      n_cmp++; if (aw_q.size() != 5 || w_q.size() != 5) begin n_err++; $display("FAIL b2b_beats: got aw %0d w %0d want 5", aw_q.size(), w_q.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (aw_at(i) !== 32'h1000 + 32'(i * 4) || w_at(i) !== {32'hA0 + 32'(i), 4'hF}) begin
            n_err++;
            $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", i, aw_at(i), w_at(i), 32'h1000 + 32'(i * 4), {32'hA0 + 32'(i), 4'hF});
         end
      end
   endtask

   task automatic test_read_after_write();
      int n;
      bit early, ar_before_b;
      slave_clear(); aw_en = 1'b1; w_en = 1'b1; b_en = 1'b0; ar_en = 1'b1; rd_val = 32'h11223344;
      do_write(32'h200, 32'h11223344, 4'hF, n);
      up_addr = 32'h200; up_rd = 1'b1;
      early = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (arvalid === 1'b1) early = 1'b1;
      end
      n_cmp++; if (early) begin n_err++; $display("FAIL raw_ar_blocked: got arvalid 1 want 0 before bvalid"); end
      b_en = 1'b1;
      ar_before_b = 1'b0;
      n = 0;
      do begin
         tick(); n++;
         if (arvalid === 1'b1 && b_tot == 0) ar_before_b = 1'b1;
      end while (up_valid !== 1'b1 && n < LIMIT);
      up_rd = 1'b0;
      n_cmp++; if (ar_before_b || up_valid !== 1'b1) begin n_err++; $display("FAIL raw_complete: got up_valid %b early_ar %b want 1/0", up_valid, ar_before_b); end
      n_cmp++; if (up_rdata !== 32'h11223344) begin n_err++; $display("FAIL raw_rdata: got %h want 11223344", up_rdata); end
      n_cmp++; if (ar_at(0) !== 32'h200) begin n_err++; $display("FAIL raw_araddr: got %h want 00000200", ar_at(0)); end
      tick(); tick();
      n_cmp++; if (up_rdata !== 32'h11223344 || up_valid !== 1'b0) begin n_err++; $display("FAIL raw_rdata_hold: got %h/%b want 11223344/0", up_rdata, up_valid); end
   endtask

   task automatic test_aw_delay();
      int n;
      bit ok, aw_dropped;
      slave_clear(); aw_en = 1'b0; w_en = 1'b1; b_en = 1'b1;
      do_write(32'h300, 32'hCAFEF00D, 4'h3, n);
      n = 0;
      while (w_tot == 0 && n < 50) begin tick(); n++; end
      n_cmp++; if (wvalid !== 1'b0 || awvalid !== 1'b1) begin n_err++; $display("FAIL awd_after_w: got wvalid %b awvalid %b want 0/1", wvalid, awvalid); end
      aw_dropped = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (awvalid !== 1'b1 || wvalid !== 1'b0) aw_dropped = 1'b1;
      end
      n_cmp++; if (aw_dropped) begin n_err++; $display("FAIL awd_aw_held: got awvalid dropped want held"); end
      aw_en = 1'b1;
      wait_empty(ok);
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (!ok || wb_empty !== 1'b1) begin n_err++; $display("FAIL awd_drain: got wb_empty %b want 1", wb_empty); end
      n_cmp++; if (aw_tot != 1 || w_tot != 1 || b_tot != 1) begin n_err++; $display("FAIL awd_one_pop: got aw %0d w %0d b %0d want 1/1/1", aw_tot, w_tot, b_tot); end
      n_cmp++; if (aw_at(0) !== 32'h300 || w_at(0) !== {32'hCAFEF00D, 4'h3}) begin n_err++; $display("FAIL awd_values: got %h/%h want 00000300/cafef00d3", aw_at(0), w_at(0)); end
   endtask

   task automatic test_write_priority();
      int n;
      slave_clear(); aw_en = 1'b1; w_en = 1'b1; b_en = 1'b1; ar_en = 1'b1; rd_val = 32'h0BADF00D;
      up_addr = 32'h500; up_wdata = 32'h77; up_wstrb = 4'hF; up_wr = 1'b1; up_rd = 1'b1;
      wait_valid(n);
      up_wr = 1'b0;
      n_cmp++; if (ar_q.size() != 0 || wb_empty !== 1'b0) begin n_err++; $display("FAIL prio_write_first: got ar %0d wb_empty %b want 0/0", ar_q.size(), wb_empty); end
      wait_valid(n);
      up_rd = 1'b0;
      n_cmp++; if (up_valid !== 1'b1 || up_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL prio_read: got %b/%h want 1/0badf00d", up_valid, up_rdata); end
      n_cmp++; if (aw_at(0) !== 32'h500 || w_at(0) !== {32'h77, 4'hF} || ar_at(0) !== 32'h500) begin n_err++; $display("FAIL prio_axi: got aw %h w %h ar %h", aw_at(0), w_at(0), ar_at(0)); end
      tick();
   endtask

   task automatic test_reset_midop();
      int n;
      bit ok;
      slave_clear(); aw_en = 1'b0; w_en = 1'b0; b_en = 1'b1; ar_en = 1'b1;
      for (int i = 0; i < 3; i++) do_write(32'h600 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF, n);
      tick();
      n_cmp++; if (awvalid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_awvalid: got %b want 1", awvalid); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0) begin n_err++; $display("FAIL rmid_valids: got aw %b w %b ar %b want 0", awvalid, wvalid, arvalid); end
      n_cmp++; if (wb_empty !== 1'b1 || up_valid !== 1'b0) begin n_err++; $display("FAIL rmid_empty: got wb_empty %b up_valid %b want 1/0", wb_empty, up_valid); end
      slave_clear(); aw_en = 1'b1; w_en = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (aw_tot != 0 || w_tot != 0) begin n_err++; $display("FAIL rmid_no_axi: got aw %0d w %0d want 0/0", aw_tot, w_tot); end
      do_write(32'h400, 32'h55AA55AA, 4'hF, n);
      wait_empty(ok);
      n_cmp++; if (!ok || aw_q.size() != 1 || aw_at(0) !== 32'h400 || w_at(0) !== {32'h55AA55AA, 4'hF}) begin n_err++; $display("FAIL rmid_fresh_write: got n %0d aw %h w %h", aw_q.size(), aw_at(0), w_at(0)); end
   endtask

   initial begin
      rst_n = 1'b0; up_addr = '0; up_rd = 1'b0; up_wr = 1'b0; up_wdata = '0; up_wstrb = '0;
      aw_en = 1'b0; w_en = 1'b0; b_en = 1'b0; ar_en = 1'b0; rd_val = '0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_after_write();
      test_aw_delay();
      test_write_priority();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish before 1ms");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered write entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port up_addr  input  32  D-cache request address (word-aligned).
REQ-005 SHALL have port up_rd  input  1  D-cache read request, level, held until up_valid.
REQ-006 SHALL have port up_wr  input  1  D-cache write request, level, held until up_valid.
REQ-007 SHALL have port up_wdata  input  32  write data.
REQ-008 SHALL have port up_wstrb  input  4  write byte strobes.
REQ-009 SHALL have port up_rdata  output  32  read data, valid while up_valid=1.
REQ-010 SHALL have port up_valid  output  1  one-cycle completion pulse for the accepted request.
REQ-011 SHALL have port wb_empty  output  1  high when no entries are buffered and no write is in flight.
REQ-012 SHALL have AXI4-Lite master ports awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bvalid/bready, araddr/arvalid/arready, rdata/rvalid/rready, with standard widths (32/1/1, 32/4/1/1, 1/1, 32/1/1, 32/1/1).

Function
REQ-013 SHALL store writes in a circular FIFO of DEPTH entries {addr, wdata, wstrb} with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-014 SHALL accept a write when up_wr=1, up_valid=0, count<DEPTH; push at the tail and assert up_valid in the next cycle (write latency 1 cycle, independent of AXI).
REQ-015 SHALL ignore up_rd/up_wr in any cycle where up_valid=1, so that one request is never accepted twice.
REQ-016 SHALL hold a write while count=DEPTH: no push, up_valid stays 0 until a pop frees an entry; acceptance occurs in the pop cycle at the earliest.
REQ-017 SHALL give up_wr priority when up_wr and up_rd are both high; the read is serviced after the write completes.
REQ-018 SHALL drain writes with FSM D_IDLE -> D_SEND -> D_RESP -> D_IDLE; D_IDLE leaves when count>0.
REQ-019 D_SEND SHALL drive awvalid=1 and wvalid=1 from the FIFO head, track AW and W handshakes independently, deassert each after its own handshake, and leave when both are done (same cycle or different cycles).
REQ-020 D_RESP SHALL drive bready=1; on bvalid it SHALL pop the head and return to D_IDLE; bresp is not checked.
REQ-021 SHALL keep awaddr/wdata/wstrb stable while the corresponding valid is high.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop; pointers SHALL both advance.
REQ-023 SHALL service reads with FSM R_IDLE -> R_DRAIN -> R_ADDR -> R_DATA -> R_IDLE; R_DRAIN waits until wb_empty=1 (read-after-write ordering, no forwarding).
REQ-024 R_ADDR SHALL drive arvalid=1, araddr=up_addr until arready; R_DATA SHALL drive rready=1 and, on rvalid, register rdata to up_rdata and pulse up_valid in the next cycle.
REQ-025 SHALL keep accepting writes while no read is pending; up_rd SHALL NOT be accepted while a write is being accepted in the same cycle.
REQ-026 SHALL hold up_rdata at its last read value outside read completions.
REQ-027 SHALL assert wb_empty = (count==0) and drain FSM in D_IDLE, combinationally.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge: count=0, head=tail=0, both FSMs idle, up_valid=0, up_rdata=0, awvalid=wvalid=arvalid=0, bready=rready=0.
REQ-029 SHALL discard buffered and in-flight writes on reset mid-operation, without completing outstanding AXI handshakes.

Verification
REQ-030 Single write addr 0x100 data 0xDEADBEEF strb 0xF, awready=wready=1, bvalid one cycle later -> up_valid the cycle after acceptance; one AW/W beat with the same values; wb_empty=1 after bvalid.
REQ-031 Five back-to-back writes with awready=0 (DEPTH=4) -> four up_valid pulses; fifth held until awready=1 and first bvalid; AXI order 1..5.
REQ-032 Write 0x200=0x11223344 then read 0x200 with the buffer non-empty -> arvalid not raised until bvalid for the write; up_rdata=slave rdata (0x11223344).
REQ-033 awready delayed 3 cycles after wready -> wvalid drops after the W handshake, awvalid stays until awready; exactly one pop.
REQ-034 rst_n=0 for 1 cycle with 3 entries buffered and awvalid high -> next cycle all valids 0, wb_empty=1, no further AXI writes.
REQ-035 Push and pop in the same cycle at count=DEPTH -> count stays DEPTH, pointers wrap correctly, data order preserved.
